// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 padder and hash core.
package sha256_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        OUT    = 2'd2,
        EXTRA  = 2'd3
    } state_e;

    localparam int         BLOCK_W     = 512;
    localparam int         BLOCK_BYTES = BLOCK_W / 8;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         LEN_OFFSET  = 56;

    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to 512-bit block padder for SHA-256: appends 0x80, zero fill
// and the 64-bit big-endian message bit length, spilling into an extra block when needed.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int MAX_LEN_BITS = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_keep,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready
);

    localparam int CNT_W = MAX_LEN_BITS - 3;

    state_e                  state_q, state_d;
    logic [6:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic                    extra_q, extra_d;
    logic                    lead80_q, lead80_d;
    logic                    blk_last_q, blk_last_d;
    logic [MAX_LEN_BITS-1:0] bit_len;

    // Byte count times eight; the counter width makes the wrap modulo 2^64 implicit.
    assign bit_len  = {byte_cnt_q, 3'b000};
    assign blk_last = blk_last_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ACCEPT;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            extra_q    <= 1'b0;
            lead80_q   <= 1'b0;
            blk_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            extra_q    <= extra_d;
            lead80_q   <= lead80_d;
            blk_last_q <= blk_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        extra_d    = extra_q;
        lead80_d   = lead80_q;
        blk_last_d = blk_last_q;
        in_ready   = 1'b0;
        blk_valid  = 1'b0;
        case (state_q)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_keep) begin
                        cnt_d      = cnt_q + 7'd1;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = PAD;
                    end else if (in_keep && cnt_q == 7'd63) begin
                        state_d    = OUT;
                        blk_last_d = 1'b0;
                    end
                end
            end
            PAD: begin
                state_d = OUT;
                if (cnt_q < 7'(LEN_OFFSET)) begin
                    blk_last_d = 1'b1;
                end else begin
                    // Length field does not fit; a second block carries it.
                    blk_last_d = 1'b0;
                    extra_d    = 1'b1;
                    lead80_d   = (cnt_q == 7'(BLOCK_BYTES));
                end
            end
            OUT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    cnt_d   = '0;
                    state_d = extra_q ? EXTRA : ACCEPT;
                    if (blk_last_q) begin
                        byte_cnt_d = '0;
                    end
                end
            end
            EXTRA: begin
                state_d    = OUT;
                blk_last_d = 1'b1;
                extra_d    = 1'b0;
                lead80_d   = 1'b0;
            end
            default: state_d = ACCEPT;
        endcase
    end

    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
        localparam logic [6:0] IDX = 7'(gi);

        logic [7:0] byte_q, byte_d;
        logic [7:0] len_byte, pad_byte, extra_byte;

        if (gi >= LEN_OFFSET) begin : g_len
            assign len_byte = bit_len[8*(BLOCK_BYTES-1-gi) +: 8];
        end else begin : g_nolen
            assign len_byte = 8'h00;
        end

        // With cnt=64 neither branch matches, so a full buffer passes through unchanged.
        always_comb begin
            pad_byte = byte_q;
            if (cnt_q == IDX) begin
                pad_byte = PAD_BYTE;
            end else if (cnt_q < IDX) begin
                pad_byte = (cnt_q < 7'(LEN_OFFSET)) ? len_byte : 8'h00;
            end
        end

        assign extra_byte = (IDX == 7'd0 && lead80_q) ? PAD_BYTE : len_byte;

        always_comb begin
            byte_d = byte_q;
            case (state_q)
                ACCEPT: if (in_valid && in_keep && cnt_q == IDX) byte_d = in_data;
                PAD:    byte_d = pad_byte;
                OUT:    if (blk_ready) byte_d = 8'h00;
                EXTRA:  byte_d = extra_byte;
                default: byte_d = byte_q;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                byte_q <= 8'h00;
            end else begin
                byte_q <= byte_d;
            end
        end

        assign blk_data[BLOCK_W-1-8*gi -: 8] = byte_q;
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized scoreboard bench for sha256_padder against a plain SHA-256 padding model.
module tb_sha256_padder;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } blk_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_keep = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready = 1'b0;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_mode = 1;

    sha256_padder #(.MAX_LEN_BITS(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: standard SHA-256 padding of the whole message, then split into 64-byte blocks.
    task automatic push_expected(input byte_q_t msg);
        logic [7:0]  p[$];
        logic [63:0] bitlen;
        blk_t        b;
        int          nblk;
        p = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
        nblk = p.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*bi + j];
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic drive_beat(input logic [7:0] d, input logic keep, input logic last);
        int t = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clock);
        end
        in_data  = d;
        in_keep  = keep;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", {511'b0, in_ready}, 512'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit zero_tail);
        push_expected(msg);
        if (msg.size() == 0) begin
            drive_beat(8'h00, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++)
                drive_beat(msg[i], 1'b1, (i == msg.size() - 1) && !zero_tail);
            if (zero_tail) drive_beat(8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk("drain_pending_blocks", 512'(exp_q.size()), 512'd0);
        repeat (2) @(negedge clock);
    endtask

    function automatic byte_q_t make_msg(input int len, input int mode);
        byte_q_t m;
        for (int i = 0; i < len; i++) m.push_back(mode == 0 ? 8'(i) : 8'($urandom_range(0, 255)));
        return m;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       blk_ready = 1'($urandom_range(0, 1));
                1:       blk_ready = 1'b1;
                default: blk_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every block handshake and checks hold behaviour.
    initial begin
        blk_t         e;
        logic         held = 1'b0;
        logic [511:0] held_data = '0;
        logic         held_last = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                held = 1'b0;
            end else begin
                if (held && blk_valid) begin
                    chk("hold_blk_data", blk_data, held_data);
                    chk("hold_blk_last", {511'b0, blk_last}, {511'b0, held_last});
                end
                if (blk_valid) chk("in_ready_during_out", {511'b0, in_ready}, 512'd0);
                if (blk_valid && blk_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_block: got %h expected no block", blk_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", blk_data, e.data);
                        chk("blk_last", {511'b0, blk_last}, {511'b0, e.last});
                    end
                end
                held      = blk_valid && !blk_ready;
                held_data = blk_data;
                held_last = blk_last;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t abc;
        byte_q_t m;
        int      lens[8] = '{0, 55, 56, 63, 64, 119, 120, 128};

        abc.push_back(8'h61);
        abc.push_back(8'h62);
        abc.push_back(8'h63);

        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_blk_valid", {511'b0, blk_valid}, 512'd0);
        chk("reset_blk_last", {511'b0, blk_last}, 512'd0);
        chk("reset_blk_data", blk_data, 512'd0);
        chk("reset_in_ready", {511'b0, in_ready}, 512'd1);
        reset = 1'b1;
        @(negedge clock);

        ready_mode = 1;
        send_msg(abc, 1'b0);
        for (int i = 0; i < 8; i++) begin
            m = make_msg(lens[i], (lens[i] == 64) ? 0 : 1);
            send_msg(m, 1'b0);
        end
        m = make_msg(64, 0);
        send_msg(m, 1'b1);
        wait_drain();

        // Back-pressure: block must appear 2 cycles after the last beat and hold while stalled.
        ready_mode = 2;
        blk_ready = 1'b0;
        send_msg(abc, 1'b0);
        chk("latency_pad_cycle", {511'b0, blk_valid}, 512'd0);
        @(negedge clock);
        chk("latency_block_valid", {511'b0, blk_valid}, 512'd1);
        repeat (5) @(negedge clock);
        chk("stall_still_valid", {511'b0, blk_valid}, 512'd1);
        ready_mode = 1;
        wait_drain();

        // Abort a partial message with reset; only the following "abc" block may appear.
        for (int i = 0; i < 10; i++) drive_beat(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_blk_valid", {511'b0, blk_valid}, 512'd0);
        chk("abort_in_ready", {511'b0, in_ready}, 512'd1);
        reset = 1'b1;
        @(negedge clock);
        send_msg(abc, 1'b0);
        wait_drain();

        ready_mode = 0;
        for (int n = 0; n < 20; n++) begin
            m = make_msg($urandom_range(0, 200), 1);
            send_msg(m, 1'($urandom_range(0, 3) == 0));
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
